// File: rtl/acc_stack_unit.sv
// Accumulator with integrated ALU, registered {V,C,N,Z} flags and a LIFO shadow
// stack that saves/restores {acc, flags} for call and interrupt context.
module acc_stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [3:0]       flags_o,
    output logic [CNT_W-1:0] depth_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       err_o
);
    localparam int MSB = WIDTH - 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] acc;
        logic [3:0]       flags;
    } ctx_t;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] depth_q;
    logic [1:0]       err_q;
    ctx_t             stack_mem [2**AW];

    logic             full, empty;
    logic             push_ok, pop_ok, push_err, pop_err, op_exec;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] res;
    logic             c_new, v_new;

    assign full    = (depth_q == CNT_W'(DEPTH));
    assign empty   = (depth_q == '0);

    // Simultaneous push and pop is a control error: neither happens.
    assign push_ok  = push_i && !pop_i && !full;
    assign pop_ok   = pop_i && !push_i && !empty;
    assign push_err = push_i && (pop_i || full);
    assign pop_err  = pop_i && (push_i || empty);
    // Any pop request, successful or not, takes priority over the ALU op.
    assign op_exec  = en_i && (op_i != OP_NOP) && !pop_i;

    assign wr_idx  = depth_q[AW-1:0];
    assign rd_idx  = AW'(depth_q - CNT_W'(1));

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, data_i};
        diff  = {1'b0, acc_q} - {1'b0, data_i};
        res   = acc_q;
        c_new = flags_q[2];
        v_new = flags_q[3];
        case (op_e'(op_i))
            OP_LOAD: res = data_i;
            OP_ADD: begin
                res   = sum[MSB:0];
                c_new = sum[WIDTH];
                v_new = (acc_q[MSB] == data_i[MSB]) && (res[MSB] != acc_q[MSB]);
            end
            OP_SUB: begin
                res   = diff[MSB:0];
                c_new = diff[WIDTH];
                v_new = (acc_q[MSB] != data_i[MSB]) && (res[MSB] != acc_q[MSB]);
            end
            OP_AND: begin res = acc_q & data_i; c_new = 1'b0; v_new = 1'b0; end
            OP_OR:  begin res = acc_q | data_i; c_new = 1'b0; v_new = 1'b0; end
            OP_XOR: begin res = acc_q ^ data_i; c_new = 1'b0; v_new = 1'b0; end
            OP_SRA: begin
                res   = {acc_q[MSB], acc_q[MSB:1]};
                c_new = acc_q[0];
                v_new = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        if (pop_ok) begin
            {acc_d, flags_d} = stack_mem[rd_idx];
        end else if (op_exec) begin
            acc_d   = res;
            flags_d = {v_new, c_new, res[MSB], (res == '0)};
        end
    end

    // NOTE: stack storage has no reset; its contents are meaningless while depth is 0.
    always_ff @(posedge clock_i) begin
        if (push_ok) stack_mem[wr_idx] <= {acc_q, flags_q};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q   <= '0;
            flags_q <= 4'b0001;
            depth_q <= '0;
            err_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            if (push_ok)     depth_q <= depth_q + CNT_W'(1);
            else if (pop_ok) depth_q <= depth_q - CNT_W'(1);
            // A new error event wins over a coincident clear.
            err_q   <= (clr_err_i ? 2'b00 : err_q) | {push_err, pop_err};
        end
    end

    assign acc_o   = acc_q;
    assign flags_o = flags_q;
    assign depth_o = depth_q;
    assign full_o  = full;
    assign empty_o = empty;
    assign err_o   = err_q;

endmodule

// File: tb/tb_acc_stack_unit.sv
// Bench for acc_stack_unit: directed vector table, mid-cycle reset sequence and
// randomized traffic checked against an arithmetic/queue reference model.
module tb_acc_stack_unit;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, push, pop, clr;
    logic [2:0]    op;
    logic [W-1:0]  data;
    logic [W-1:0]  acc;
    logic [3:0]    flags;
    logic [CW-1:0] depth;
    logic          full, empty;
    logic [1:0]    err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clock_i(clk), .rst_n_i(rst_n), .en_i(en), .op_i(op), .data_i(data),
        .push_i(push), .pop_i(pop), .clr_err_i(clr), .acc_o(acc), .flags_o(flags),
        .depth_o(depth), .full_o(full), .empty_o(empty), .err_o(err)
    );

    typedef struct {
        logic         en;
        logic [2:0]   op;
        logic [W-1:0] data;
        logic         push, pop, clr;
        logic [W-1:0] acc;
        logic [3:0]   flags;
        int           depth;
        logic [1:0]   err;
    } vec_t;

    typedef struct {
        logic [W-1:0] acc;
        logic [3:0]   flags;
    } ctx_t;

    vec_t         vecs[$];
    ctx_t         m_stack[$];
    logic [W-1:0] m_acc;
    logic [3:0]   m_flags;
    logic [1:0]   m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] e_acc, input logic [3:0] e_flags,
                             input int e_depth, input logic [1:0] e_err);
        check({tag, " acc"},   32'(acc),   32'(e_acc));
        check({tag, " flags"}, 32'(flags), 32'(e_flags));
        check({tag, " depth"}, 32'(depth), 32'(e_depth));
        check({tag, " full"},  32'(full),  32'(e_depth == D));
        check({tag, " empty"}, 32'(empty), 32'(e_depth == 0));
        check({tag, " err"},   32'(err),   32'(e_err));
    endtask

    task automatic drive(input logic e, input logic [2:0] o, input logic [W-1:0] d,
                         input logic pu, input logic po, input logic cl);
        en = e; op = o; data = d; push = pu; pop = po; clr = cl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic e, input logic [2:0] o, input logic [W-1:0] d,
                                input logic pu, input logic po, input logic cl,
                                input logic [W-1:0] a, input logic [3:0] f, input int dp,
                                input logic [1:0] er);
        vec_t v;
        v.en = e; v.op = o; v.data = d; v.push = pu; v.pop = po; v.clr = cl;
        v.acc = a; v.flags = f; v.depth = dp; v.err = er;
        return v;
    endfunction

    function automatic int to_signed(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - (1 << W) : int'(x);
    endfunction

    // Reference model: plain integer arithmetic and a queue for the stack.
    task automatic model_cycle(input logic e, input logic [2:0] o, input logic [W-1:0] d,
                               input logic pu, input logic po, input logic cl);
        logic [1:0] ev = 2'b00;
        int a_u = int'(m_acc), d_u = int'(d);
        int a_s = to_signed(m_acc), d_s = to_signed(d);
        int r = a_u, s;
        logic c = m_flags[2], v = m_flags[3];
        if (pu && po) begin
            ev = 2'b11;
        end else if (po) begin
            if (m_stack.size() == 0) ev[0] = 1'b1;
            else begin
                ctx_t top = m_stack.pop_back();
                m_acc = top.acc; m_flags = top.flags;
            end
        end else begin
            if (pu) begin
                if (m_stack.size() == D) ev[1] = 1'b1;
                else m_stack.push_back('{m_acc, m_flags});
            end
            if (e && o != 3'd0) begin
                case (o)
                    3'd1: r = d_u;
                    3'd2: begin r = a_u + d_u; c = (r >= (1 << W)); s = a_s + d_s;
                                v = (s >= (1 << (W-1))) || (s < -(1 << (W-1))); end
                    3'd3: begin r = a_u - d_u; c = (a_u < d_u); s = a_s - d_s;
                                v = (s >= (1 << (W-1))) || (s < -(1 << (W-1))); end
                    3'd4: begin r = a_u & d_u; c = 0; v = 0; end
                    3'd5: begin r = a_u | d_u; c = 0; v = 0; end
                    3'd6: begin r = a_u ^ d_u; c = 0; v = 0; end
                    default: begin r = a_s >>> 1; c = a_u[0]; v = 0; end
                endcase
                m_acc = r[W-1:0];
                m_flags = {v, c, m_acc[W-1], m_acc == 0};
            end
        end
        m_err = (cl ? 2'b00 : m_err) | ev;
    endtask

    function automatic logic [W-1:0] pick_data();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {1'b0, {(W-1){1'b1}}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return '1;
            4: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        drive(0, 0, '0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        check_all("reset", '0, 4'b0001, 0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        //               en op    data      pu po cl  acc       flags    d  err
        vecs.push_back(mk(1, 3'd1, 16'h7FFF, 0, 0, 0, 16'h7FFF, 4'b0000, 0, 2'b00));
        vecs.push_back(mk(1, 3'd2, 16'h0001, 0, 0, 0, 16'h8000, 4'b1010, 0, 2'b00));
        vecs.push_back(mk(1, 3'd1, 16'h0003, 0, 0, 0, 16'h0003, 4'b1000, 0, 2'b00));
        vecs.push_back(mk(1, 3'd3, 16'h0005, 0, 0, 0, 16'hFFFE, 4'b0110, 0, 2'b00));
        vecs.push_back(mk(1, 3'd7, 16'h0000, 0, 0, 0, 16'hFFFF, 4'b0010, 0, 2'b00));
        vecs.push_back(mk(1, 3'd1, 16'h00A5, 0, 0, 0, 16'h00A5, 4'b0000, 0, 2'b00));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 0, 0, 16'h00A5, 4'b0000, 1, 2'b00));
        vecs.push_back(mk(1, 3'd1, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001, 1, 2'b00));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 1, 0, 16'h00A5, 4'b0000, 0, 2'b00));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0, 3'd0, 16'h0, 1, 0, 0, 16'h00A5, 4'b0000, (i > 4) ? 4 : i,
                              (i > 4) ? 2'b10 : 2'b00));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 0, 1, 16'h00A5, 4'b0000, 4, 2'b00));
        for (int i = 3; i >= 0; i--)
            vecs.push_back(mk(0, 3'd0, 16'h0, 0, 1, 0, 16'h00A5, 4'b0000, i, 2'b00));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 1, 0, 16'h00A5, 4'b0000, 0, 2'b01));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 1, 1, 16'h00A5, 4'b0000, 0, 2'b01));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 0, 1, 16'h00A5, 4'b0000, 0, 2'b00));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 0, 0, 16'h00A5, 4'b0000, 1, 2'b00));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 0, 0, 16'h00A5, 4'b0000, 2, 2'b00));
        vecs.push_back(mk(1, 3'd2, 16'h0001, 1, 1, 0, 16'h00A5, 4'b0000, 2, 2'b11));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 0, 1, 16'h00A5, 4'b0000, 2, 2'b00));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 0, 0, 16'h00A5, 4'b0000, 3, 2'b00));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 0, 0, 16'h00A5, 4'b0000, 4, 2'b00));
        vecs.push_back(mk(1, 3'd2, 16'h0100, 1, 0, 0, 16'h01A5, 4'b0000, 4, 2'b10));
        vecs.push_back(mk(1, 3'd1, 16'h1234, 0, 1, 0, 16'h00A5, 4'b0000, 3, 2'b10));
        vecs.push_back(mk(0, 3'd1, 16'hFFFF, 0, 0, 1, 16'h00A5, 4'b0000, 3, 2'b00));
        vecs.push_back(mk(1, 3'd6, 16'h00A5, 0, 0, 0, 16'h0000, 4'b0001, 3, 2'b00));
        vecs.push_back(mk(1, 3'd5, 16'h8000, 0, 0, 0, 16'h8000, 4'b0010, 3, 2'b00));
        vecs.push_back(mk(1, 3'd4, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001, 3, 2'b00));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].op, vecs[i].data, vecs[i].push, vecs[i].pop, vecs[i].clr);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].acc, vecs[i].flags, vecs[i].depth, vecs[i].err);
        end

        // Mid-cycle reset with three live stack entries and a push in flight.
        drive(0, 0, '0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        drive(1, 3'd1, 16'h1234, 0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 3'd0, '0, 1, 0, 0);
            step();
        end
        check_all("pre_rst", 16'h1234, 4'b0000, 3, 2'b00);
        #3 rst_n = 1'b0;
        #1 check_all("async_rst", '0, 4'b0001, 0, 2'b00);
        drive(0, 0, '0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        m_acc = '0; m_flags = 4'b0001; m_err = 2'b00; m_stack.delete();
        for (int i = 0; i < 400; i++) begin
            logic e, pu, po, cl;
            logic [2:0] o;
            logic [W-1:0] d;
            e  = ($urandom_range(0, 9) != 0);
            o  = 3'($urandom_range(0, 7));
            d  = pick_data();
            pu = ($urandom_range(0, 3) == 0);
            po = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 9) == 0);
            drive(e, o, d, pu, po, cl);
            model_cycle(e, o, d, pu, po, cl);
            step();
            check_all($sformatf("rnd%0d", i), m_acc, m_flags, m_stack.size(), m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
